param_multicycle_cpu: RTL and testbench

//  Parametrised multicycle processor core, successor to the fixed 16-bit/8-register datapath.

---
 rtl/param_multicycle_cpu.sv | 175 +++++++++++++++++
 tb/tb_param_multicycle_cpu.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_multicycle_cpu.sv
// rtl/param_multicycle_cpu.sv - parametrised multicycle processor core with run/done handshake
module param_multicycle_cpu #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        run,
    input  logic [DATA_W-1:0]           iin,
    output logic                        busy,
    output logic                        done,
    output logic                        illegal,
    output logic [DATA_W-1:0]           bus,
    output logic                        flag_z,
    output logic                        flag_c,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]           dbg_data
);

    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int IMM_W  = DATA_W - 3 - REG_AW;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    logic [1:0]        state;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] r_reg;

    logic [2:0]        op;
    logic [REG_AW-1:0] rx;
    logic [REG_AW-1:0] ry;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic              wr_en;

    // Instruction fields; the immediate shares the rY positions and runs down to bit 0
    assign op      = ir[DATA_W-1 -: 3];
    assign rx      = ir[DATA_W-4 -: REG_AW];
    assign ry      = ir[IMM_W-1 -: REG_AW];
    assign imm_ext = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

    assign busy     = (state != T0);
    assign dbg_data = regs[dbg_sel];

    // Register-file write happens at the final edge of mv/mvi (T1) and of ALU ops (T3)
    assign wr_en = ((state == T1) && ((op == OP_MV) || (op == OP_MVI))) || (state == T3);

    // Bus source selection per step
    always_comb begin
        bus = '0;
        case (state)
            T1: begin
                case (op)
                    OP_MV:   bus = regs[ry];
                    OP_MVI:  bus = imm_ext;
                    OP_ILL:  bus = '0;
                    default: bus = regs[rx];
                endcase
            end
            T2:      bus = regs[ry];
            T3:      bus = r_reg;
            default: bus = '0;
        endcase
    end

    // ALU: A operand from staging register, B operand from the bus; carry of sub is no-borrow
    always_comb begin
        sum_ext  = {1'b0, a_reg} + {1'b0, bus};
        diff_ext = {1'b0, a_reg} - {1'b0, bus};
        alu_res  = '0;
        alu_c    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ext[DATA_W-1:0];
                alu_c   = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_res = diff_ext[DATA_W-1:0];
                alu_c   = ~diff_ext[DATA_W];
            end
            OP_AND:  alu_res = a_reg & bus;
            OP_OR:   alu_res = a_reg | bus;
            OP_XOR:  alu_res = a_reg ^ bus;
            default: alu_res = '0;
        endcase
    end

    // Step sequencer with instruction latch and registered completion pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= T0;
            ir      <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                T0: begin
                    if (run) begin
                        ir    <= iin;
                        state <= T1;
                    end
                end
                T1: begin
                    case (op)
                        OP_MV, OP_MVI: begin
                            state <= T0;
                            done  <= 1'b1;
                        end
                        OP_ILL: begin
                            state   <= T0;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end
                        default: state <= T2;
                    endcase
                end
                T2:      state <= T3;
                default: begin
                    state <= T0;
                    done  <= 1'b1;
                end
            endcase
        end
    end

    // General register file, written from the bus
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rx] <= bus;
        end
    end

    // A/R staging registers and flags, updated only by ALU instructions
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg  <= '0;
            r_reg  <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if ((state == T1) && (op != OP_MV) && (op != OP_MVI) && (op != OP_ILL)) begin
                a_reg <= bus;
            end
            if (state == T2) begin
                r_reg  <= alu_res;
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_param_multicycle_cpu.sv
// tb/tb_param_multicycle_cpu.sv - randomized self-checking bench for param_multicycle_cpu
module tb_param_multicycle_cpu;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int IMM_W    = DATA_W - 3 - REG_AW;
    localparam longint MODV = longint'(1) << DATA_W;

    logic              clk = 1'b0;
    logic              resetn;
    logic              run;
    logic [DATA_W-1:0] iin;
    logic              busy;
    logic              done;
    logic              illegal;
    logic [DATA_W-1:0] bus;
    logic              flag_z;
    logic              flag_c;
    logic [REG_AW-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    longint            mreg [NUM_REGS];
    bit                mz;
    bit                mc;
    logic [DATA_W-1:0] bus_seen [8];
    logic              busy_seen [8];

    param_multicycle_cpu #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .resetn(resetn), .run(run), .iin(iin), .busy(busy), .done(done),
        .illegal(illegal), .bus(bus), .flag_z(flag_z), .flag_c(flag_c),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] mk_rr(input int op, input int rx, input int ry);
        longint v;
        v = (longint'(op) << (DATA_W-3)) | (longint'(rx) << IMM_W) | (longint'(ry) << (IMM_W-REG_AW));
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] mk_imm(input int rx, input int imm);
        longint v;
        v = (longint'(1) << (DATA_W-3)) | (longint'(rx) << IMM_W) | (longint'(imm) & ((longint'(1) << IMM_W) - 1));
        return v[DATA_W-1:0];
    endfunction

    // Reference: architectural effect of one instruction using plain integer arithmetic
    task automatic model_exec(input logic [DATA_W-1:0] instr, output int elat, output bit eill);
        longint iv, a, b, imm, res, full;
        int op, rx, ry;
        bit c;
        iv  = longint'(instr);
        op  = int'(iv / (longint'(1) << (DATA_W-3)));
        rx  = int'((iv / (longint'(1) << IMM_W)) % NUM_REGS);
        ry  = int'((iv / (longint'(1) << (IMM_W-REG_AW))) % NUM_REGS);
        imm = iv % (longint'(1) << IMM_W);
        if (imm >= (longint'(1) << (IMM_W-1))) imm = imm - (longint'(1) << IMM_W);
        a = mreg[rx];
        b = mreg[ry];
        eill = 1'b0;
        elat = 2;
        res = 0;
        c = 1'b0;
        case (op)
            0: mreg[rx] = b;
            1: mreg[rx] = (imm + MODV) % MODV;
            7: eill = 1'b1;
            default: begin
                elat = 4;
                case (op)
                    2: begin full = a + b; res = full % MODV; c = (full >= MODV); end
                    3: begin res = (a - b + MODV) % MODV; c = (a >= b); end
                    4: res = a & b;
                    5: res = a | b;
                    default: res = a ^ b;
                endcase
                mreg[rx] = res;
                mz = (res == 0);
                mc = c;
            end
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mreg[i] = 0;
        mz = 1'b0;
        mc = 1'b0;
    endtask

    // Entered and left at posedge+1; returns in the cycle where done is observed high
    task automatic issue(input logic [DATA_W-1:0] instr, input bit hold, output int lat, output logic ill);
        run = 1'b1;
        iin = instr;
        @(posedge clk); #1;
        if (!hold) run = 1'b0;
        else iin = DATA_W'($urandom);
        lat = 0;
        ill = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_seen[i]  = bus;
            busy_seen[i] = busy;
            @(posedge clk); #1;
            if (done) begin
                lat = i + 2;
                ill = illegal;
                break;
            end
        end
        run = 1'b0;
    endtask

    task automatic exec(input logic [DATA_W-1:0] instr, input bit hold, output int lat, output logic ill,
                        output int elat, output bit eill);
        model_exec(instr, elat, eill);
        issue(instr, hold, lat, ill);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        run = 1'b0;
        iin = '0;
        dbg_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        total++;
        if ({busy, done, illegal, flag_z, flag_c, bus} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b ill=%b z=%b c=%b bus=%h want all 0",
                     busy, done, illegal, flag_z, flag_c, bus);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_sel = REG_AW'(i);
            #1;
            total++;
            if (dbg_data !== '0) begin
                bad++;
                $display("FAIL reset_reg%0d: got %h want 0000", i, dbg_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mvi();
        int lat, elat;
        logic ill;
        bit eill;
        exec(mk_imm(0, 5), 1'b0, lat, ill, elat, eill);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL mvi_r0_latency: got %0d want 2", lat); end
        exec(mk_imm(1, -3), 1'b0, lat, ill, elat, eill);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL mvi_r1_latency: got %0d want 2", lat); end
        dbg_sel = 0; #1;
        total++;
        if (dbg_data !== 16'h0005) begin bad++; $display("FAIL mvi_r0_value: got %h want 0005", dbg_data); end
        dbg_sel = 1; #1;
        total++;
        if (dbg_data !== 16'hFFFD) begin bad++; $display("FAIL mvi_r1_value: got %h want fffd", dbg_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat, elat;
        logic ill;
        bit eill;
        exec(mk_rr(2, 0, 1), 1'b0, lat, ill, elat, eill);
        total++;
        if ({bus_seen[0], bus_seen[1], bus_seen[2]} !== {16'h0005, 16'hFFFD, 16'h0002}) begin
            bad++;
            $display("FAIL add_bus_steps: got %h %h %h want 0005 fffd 0002", bus_seen[0], bus_seen[1], bus_seen[2]);
        end
        total++;
        if (busy_seen[0] !== 1'b1) begin bad++; $display("FAIL add_busy: got %b want 1", busy_seen[0]); end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL add_latency: got %0d want 4", lat); end
        total++;
        if ({flag_z, flag_c} !== 2'b01) begin bad++; $display("FAIL add_flags: got z=%b c=%b want z=0 c=1", flag_z, flag_c); end
        dbg_sel = 0; #1;
        total++;
        if (dbg_data !== 16'h0002) begin bad++; $display("FAIL add_r0: got %h want 0002", dbg_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_xor();
        int lat, elat;
        logic ill;
        bit eill;
        exec(mk_imm(4, 'h123), 1'b0, lat, ill, elat, eill);
        repeat (4) exec(mk_rr(2, 4, 4), 1'b0, lat, ill, elat, eill);
        exec(mk_imm(5, 4), 1'b0, lat, ill, elat, eill);
        exec(mk_rr(2, 4, 5), 1'b0, lat, ill, elat, eill);
        exec(mk_rr(0, 2, 4), 1'b0, lat, ill, elat, eill);
        dbg_sel = 2; #1;
        total++;
        if (dbg_data !== 16'h1234) begin bad++; $display("FAIL build_r2: got %h want 1234", dbg_data); end
        exec(mk_rr(3, 2, 2), 1'b0, lat, ill, elat, eill);
        total++;
        if ({dbg_data, flag_z, flag_c} !== {16'h0000, 2'b11}) begin
            bad++;
            $display("FAIL sub_self: got r2=%h z=%b c=%b want 0000 z=1 c=1", dbg_data, flag_z, flag_c);
        end
        exec(mk_rr(6, 0, 0), 1'b0, lat, ill, elat, eill);
        total++;
        if ({flag_z, flag_c} !== 2'b10) begin bad++; $display("FAIL xor_self: got z=%b c=%b want z=1 c=0", flag_z, flag_c); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_and_hold();
        int lat, elat;
        logic ill;
        bit eill;
        logic [DATA_W-1:0] exp;
        exec(mk_rr(7, 3, 1) | DATA_W'($urandom_range(0, 127)), 1'b0, lat, ill, elat, eill);
        total++;
        if ({lat == 2, ill} !== 2'b11) begin bad++; $display("FAIL illegal_pulse: got lat=%0d ill=%b want lat=2 ill=1", lat, ill); end
        total++;
        if ({flag_z, flag_c} !== {mz, mc}) begin bad++; $display("FAIL illegal_flags: got z=%b c=%b want z=%b c=%b", flag_z, flag_c, mz, mc); end
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_sel = REG_AW'(i); #1;
            exp = mreg[i][DATA_W-1:0];
            total++;
            if (dbg_data !== exp) begin bad++; $display("FAIL illegal_reg%0d: got %h want %h", i, dbg_data, exp); end
        end
        @(posedge clk); #1;
        exec(mk_imm(6, 'h0F0), 1'b0, lat, ill, elat, eill);
        exec(mk_imm(7, 'h10F), 1'b0, lat, ill, elat, eill);
        dbg_sel = 6;
        exec(mk_rr(2, 6, 7), 1'b1, lat, ill, elat, eill);
        total++;
        if ({lat == 4, ill} !== 2'b10) begin bad++; $display("FAIL hold_latency: got lat=%0d ill=%b want lat=4 ill=0", lat, ill); end
        exp = mreg[6][DATA_W-1:0];
        total++;
        if (dbg_data !== exp) begin bad++; $display("FAIL hold_result: got %h want %h", dbg_data, exp); end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL hold_single_exec: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back_random();
        int lat, elat;
        logic ill;
        bit eill;
        logic [DATA_W-1:0] exp;
        for (int n = 0; n < 60; n++) begin
            dbg_sel = REG_AW'($urandom);
            exec(DATA_W'($urandom), 1'b0, lat, ill, elat, eill);
            exp = mreg[dbg_sel][DATA_W-1:0];
            total++;
            if ({lat, ill, flag_z, flag_c, dbg_data} !== {elat, eill, mz, mc, exp}) begin
                bad++;
                $display("FAIL random_%0d: got lat=%0d ill=%b z=%b c=%b r%0d=%h want lat=%0d ill=%b z=%b c=%b r=%h",
                         n, lat, ill, flag_z, flag_c, dbg_sel, dbg_data, elat, eill, mz, mc, exp);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, elat;
        logic ill;
        bit eill;
        exec(mk_imm(3, 'h40), 1'b0, lat, ill, elat, eill);
        run = 1'b1;
        iin = mk_rr(2, 3, 3);
        @(posedge clk); #1;
        run = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, bus} !== {1'b1, 16'h0040}) begin bad++; $display("FAIL mid_t2_bus: got busy=%b bus=%h want 1 0040", busy, bus); end
        resetn = 1'b0;
        model_reset();
        #1;
        total++;
        if ({busy, done, illegal, flag_z, flag_c, bus} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b ill=%b z=%b c=%b bus=%h want all 0",
                     busy, done, illegal, flag_z, flag_c, bus);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_sel = REG_AW'(i); #1;
            total++;
            if (dbg_data !== '0) begin bad++; $display("FAIL mid_reset_reg%0d: got %h want 0000", i, dbg_data); end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        dbg_sel = 3;
        exec(mk_imm(3, 7), 1'b0, lat, ill, elat, eill);
        total++;
        if ({lat == 2, dbg_data} !== {1'b1, 16'h0007}) begin bad++; $display("FAIL after_reset_mvi: got lat=%0d r3=%h want 2 0007", lat, dbg_data); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_sub_xor();
        test_illegal_and_hold();
        test_back_to_back_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
